// File: rtl/divider_if.sv
// Divider request/response bundle between the execute stage and the
// iterative divider. The execute stage is the master; the divider is the slave.
interface divider_if;
  localparam int DATA_WIDTH = 32;

  logic                  div_req;
  logic [1:0]            div_op;
  logic [DATA_WIDTH-1:0] div_oprand_0;
  logic [DATA_WIDTH-1:0] div_oprand_1;
  logic                  div_flush;
  logic                  div_busy;
  logic                  div_done;
  logic [DATA_WIDTH-1:0] div_result;

  modport master (
    output div_req,
    output div_op,
    output div_oprand_0,
    output div_oprand_1,
    output div_flush,
    input  div_busy,
    input  div_done,
    input  div_result
  );

  modport slave (
    input  div_req,
    input  div_op,
    input  div_oprand_0,
    input  div_oprand_1,
    input  div_flush,
    output div_busy,
    output div_done,
    output div_result
  );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle: accept in IDLE, 32 CALC steps, one FIX cycle
// that applies signs and the divide-by-zero / signed-overflow overrides.
// Optional feature: define CORE_DIV_EARLY_OUT_EN to finish divide-by-zero and
// signed-overflow requests in the cycle after acceptance without going busy.
// Result values are identical with and without the macro.
module divider (
  input  logic     clk,
  input  logic     rst_b,
  divider_if.slave div_bus
);

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Architectural result of the two special cases. Divide-by-zero takes
  // priority: the quotient is all ones and the remainder is the dividend.
  function automatic logic [DATA_WIDTH-1:0] special_result(
    input logic [1:0]            op,
    input logic [DATA_WIDTH-1:0] dividend,
    input logic                  dvz
  );
    logic [DATA_WIDTH-1:0] res;
    if (dvz) begin
      if (op[1]) begin
        res = dividend;
      end else begin
        res = 32'hFFFF_FFFF;
      end
    end else begin
      if (op[1]) begin
        res = 32'h0000_0000;
      end else begin
        res = 32'h8000_0000;
      end
    end
    return res;
  endfunction

  // Registered state
  state_e                state_q;
  logic [5:0]            cnt_q;
  logic [1:0]            op_q;
  logic                  sign0_q;
  logic                  sign1_q;
  logic                  dvz_q;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH:0]   rem_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;

  // Request decode
  logic                  req_signed_s;
  logic                  req_neg0_s;
  logic                  req_neg1_s;
  logic                  req_dvz_s;
  logic                  req_ovf_s;
  logic [DATA_WIDTH-1:0] req_mag0_s;
  logic [DATA_WIDTH-1:0] req_mag1_s;
  logic                  accept_s;

  // One restoring step and the FIX-cycle result
  logic [DATA_WIDTH:0]   shifted_s;
  logic                  trial_ge_s;
  logic [DATA_WIDTH:0]   trial_s;
  logic [DATA_WIDTH:0]   rem_d;
  logic [DATA_WIDTH-1:0] quo_d;
  logic [DATA_WIDTH-1:0] quo_fix_s;
  logic [DATA_WIDTH-1:0] rem_fix_s;
  logic [DATA_WIDTH-1:0] result_d;

  // Decode the incoming request: signedness, magnitudes and special cases.
  always_comb begin
    req_signed_s = ~div_bus.div_op[0];
    req_neg0_s   = req_signed_s & div_bus.div_oprand_0[DATA_WIDTH-1];
    req_neg1_s   = req_signed_s & div_bus.div_oprand_1[DATA_WIDTH-1];
    req_dvz_s    = (div_bus.div_oprand_1 == 32'h0000_0000);
    req_ovf_s    = req_signed_s
                 & (div_bus.div_oprand_0 == 32'h8000_0000)
                 & (div_bus.div_oprand_1 == 32'hFFFF_FFFF);
    if (req_neg0_s) begin
      req_mag0_s = 32'h0000_0000 - div_bus.div_oprand_0;
    end else begin
      req_mag0_s = div_bus.div_oprand_0;
    end
    if (req_neg1_s) begin
      req_mag1_s = 32'h0000_0000 - div_bus.div_oprand_1;
    end else begin
      req_mag1_s = div_bus.div_oprand_1;
    end
    // A flush in the same cycle as a request always wins.
    accept_s = (state_q == IDLE) & div_bus.div_req & ~div_bus.div_flush;
  end

  // Restoring step: shift {rem,quo} left, trial-subtract the divisor and keep
  // the difference only when it is non-negative.
  always_comb begin
    shifted_s  = {rem_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
    // The full-width compare includes rem_q's top bit, so a non-zero top bit
    // (never produced by a correct step) would still read as "fits".
    trial_ge_s = ({rem_q, quo_q[DATA_WIDTH-1]} >= {2'b00, divisor_q});
    trial_s    = shifted_s - {1'b0, divisor_q};
    if (trial_ge_s) begin
      rem_d = trial_s;
      quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted_s;
      quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // FIX-cycle result: restore signs, then let the special cases override.
  always_comb begin
    if (sign0_q ^ sign1_q) begin
      quo_fix_s = 32'h0000_0000 - quo_q;
    end else begin
      quo_fix_s = quo_q;
    end
    if (sign0_q) begin
      rem_fix_s = 32'h0000_0000 - rem_q[DATA_WIDTH-1:0];
    end else begin
      rem_fix_s = rem_q[DATA_WIDTH-1:0];
    end
    if (dvz_q | ovf_q) begin
      result_d = special_result(op_q, dividend_q, dvz_q);
    end else if (op_q[1]) begin
      result_d = rem_fix_s;
    end else begin
      result_d = quo_fix_s;
    end
  end

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      op_q       <= 2'b00;
      sign0_q    <= 1'b0;
      sign1_q    <= 1'b0;
      dvz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      dividend_q <= 32'h0000_0000;
      divisor_q  <= 32'h0000_0000;
      quo_q      <= 32'h0000_0000;
      rem_q      <= 33'h0_0000_0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'h0000_0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_q       <= div_bus.div_op;
            sign0_q    <= req_neg0_s;
            sign1_q    <= req_neg1_s;
            dvz_q      <= req_dvz_s;
            ovf_q      <= req_ovf_s;
            dividend_q <= div_bus.div_oprand_0;
            divisor_q  <= req_mag1_s;
            quo_q      <= req_mag0_s;
            rem_q      <= 33'h0_0000_0000;
            cnt_q      <= 6'd0;
`ifdef CORE_DIV_EARLY_OUT_EN
            if (req_dvz_s | req_ovf_s) begin
              result_q <= special_result(div_bus.div_op, div_bus.div_oprand_0, req_dvz_s);
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
`else
            busy_q  <= 1'b1;
            state_q <= CALC;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (div_bus.div_flush) begin
            busy_q  <= 1'b0;
            cnt_q   <= 6'd0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_q <= FIX;
            end else begin
              state_q <= CALC;
            end
          end
        end
        FIX: begin
          if (div_bus.div_flush) begin
            busy_q  <= 1'b0;
            cnt_q   <= 6'd0;
            state_q <= IDLE;
          end else begin
            result_q <= result_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= 6'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign div_bus.div_busy   = busy_q;
  assign div_bus.div_done   = done_q;
  assign div_bus.div_result = result_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed test-plan cases, request-while-
// busy, flush, mid-operation reset and randomized operations against an
// arithmetic reference model.
module tb_divider;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  divider_if bus ();

  divider dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .div_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare and report one observed value against its expectation.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle, sampling point 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RV32M reference semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int   sa;
    int   sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   if (b == 32'd0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return 32'(sa / sb);
      2'b01:   if (b == 32'd0) return 32'hFFFF_FFFF; else return a / b;
      2'b10:   if (b == 32'd0) return a; else if (ovf) return 32'd0; else return 32'(sa % sb);
      default: if (b == 32'd0) return a; else return a % b;
    endcase
  endfunction

  // Cycle in which done is expected, counted from the accept cycle 0.
  function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef CORE_DIV_EARLY_OUT_EN
    if (special) return 1;
    else return 34;
`else
    if (special) return 34;
    else return 34;
`endif
  endfunction

  // Step from cycle k0 until done (or the limit); reports the done cycle
  // (0 if none) and how many cycles busy was seen high before it.
  task automatic wait_done(input int k0, input int limit, output int dc, output int bc);
    dc = 0;
    bc = 0;
    for (int k = k0; k <= limit && dc == 0; k++) begin
      if (bus.div_done === 1'b1) begin
        dc = k;
      end else begin
        if (bus.div_busy === 1'b1) bc++;
        step();
      end
    end
  endtask

  // Issue one request in the current cycle and check latency, busy and result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int dc;
    int bc;
    int lat;
    lat = latency(op, a, b);
    bus.div_req      = 1'b1;
    bus.div_op       = op;
    bus.div_oprand_0 = a;
    bus.div_oprand_1 = b;
    step();
    bus.div_req      = 1'b0;
    bus.div_op       = 2'($urandom_range(0, 3));
    bus.div_oprand_0 = $urandom;
    bus.div_oprand_1 = $urandom;
    wait_done(1, 40, dc, bc);
    check_eq({tag, " done cycle"}, 32'(dc), 32'(lat));
    check_eq({tag, " result"}, bus.div_result, model(op, a, b));
    check_eq({tag, " busy cycles"}, 32'(bc), 32'(lat - 1));
    check_eq({tag, " busy at done"}, 32'(bus.div_busy), 32'd0);
  endtask

  initial begin
    int          dc;
    int          bc;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    errors = 0;
    bus.div_req      = 1'b0;
    bus.div_op       = 2'b00;
    bus.div_oprand_0 = 32'd0;
    bus.div_oprand_1 = 32'd0;
    bus.div_flush    = 1'b0;
    rst_b            = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) step();
    check_eq("reset busy", 32'(bus.div_busy), 32'd0);
    check_eq("reset done", 32'(bus.div_done), 32'd0);
    check_eq("reset result", bus.div_result, 32'd0);
    rst_b = 1'b1;
    step();

    // Directed cases, issued back to back in each done cycle.
    run_op("div 100/7", 2'b00, 32'd100, 32'd7);
    run_op("rem 100/7", 2'b10, 32'd100, 32'd7);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu big/2", 2'b01, 32'hFFFF_FFF9, 32'd2);
    run_op("remu big/2", 2'b11, 32'hFFFF_FFF9, 32'd2);
    run_op("divu by zero", 2'b01, 32'h1234_5678, 32'd0);
    run_op("remu by zero", 2'b11, 32'h1234_5678, 32'd0);
    run_op("div -5/0", 2'b00, 32'hFFFF_FFFB, 32'd0);
    run_op("rem -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0);
    run_op("div overflow", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu no overflow", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // Request while busy (cycle 5) is ignored.
    bus.div_req = 1'b1; bus.div_op = 2'b00; bus.div_oprand_0 = 32'd1000; bus.div_oprand_1 = 32'd7;
    step();
    bus.div_req = 1'b0;
    for (int k = 1; k < 5; k++) step();
    bus.div_req = 1'b1; bus.div_op = 2'b01; bus.div_oprand_0 = 32'd50; bus.div_oprand_1 = 32'd5;
    step();
    bus.div_req = 1'b0;
    wait_done(6, 40, dc, bc);
    check_eq("ignored req done cycle", 32'(dc), 32'd34);
    check_eq("ignored req result", bus.div_result, 32'd142);
    step();
    check_eq("no second done", 32'(bus.div_done), 32'd0);
    check_eq("no second busy", 32'(bus.div_busy), 32'd0);

    // Flush in cycle 10, new DIVU 9/3 in cycle 11.
    bus.div_req = 1'b1; bus.div_op = 2'b00; bus.div_oprand_0 = 32'd12345; bus.div_oprand_1 = 32'd67;
    step();
    bus.div_req = 1'b0;
    for (int k = 1; k < 10; k++) step();
    check_eq("busy before flush", 32'(bus.div_busy), 32'd1);
    bus.div_flush = 1'b1;
    step();
    bus.div_flush = 1'b0;
    check_eq("flush busy", 32'(bus.div_busy), 32'd0);
    check_eq("flush done", 32'(bus.div_done), 32'd0);
    check_eq("flush result held", bus.div_result, 32'd142);
    bus.div_req = 1'b1; bus.div_op = 2'b01; bus.div_oprand_0 = 32'd9; bus.div_oprand_1 = 32'd3;
    step();
    bus.div_req = 1'b0;
    wait_done(12, 60, dc, bc);
    check_eq("after flush done cycle", 32'(dc), 32'd45);
    check_eq("after flush result", bus.div_result, 32'd3);
    check_eq("after flush busy cycles", 32'(bc), 32'd33);

    // Reset in cycle 20 of an operation.
    bus.div_req = 1'b1; bus.div_op = 2'b11; bus.div_oprand_0 = 32'd1000000; bus.div_oprand_1 = 32'd33;
    step();
    bus.div_req = 1'b0;
    for (int k = 1; k < 20; k++) step();
    check_eq("busy before reset", 32'(bus.div_busy), 32'd1);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    check_eq("midop reset busy", 32'(bus.div_busy), 32'd0);
    check_eq("midop reset result", bus.div_result, 32'd0);
    wait_done(21, 70, dc, bc);
    check_eq("midop reset no done", 32'(dc), 32'd0);
    check_eq("midop reset no busy", 32'(bc), 32'd0);

    // Randomized operations, with forced special cases and small divisors.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = 32'($urandom_range(1, 20));
        4:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = rb;
      endcase
      run_op("random", rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
